action_arbiter: RTL

Shares the single motor-command channel between three action requesters: the safety monitor, `navigation_fsm` (`action_req`/`action_valid`), and the inspection block. It sits between those producers and the motor driver. It gates each requester by the task state from `task_fsm`, applies fixed priority, and holds every issued command for a minimum time. It also preempts a held command for safety and latches a fault if the driver stops accepting commands.

---
 rtl/nav_pkg.sv | 49 ++++
 rtl/action_prio_sel.sv | 52 +++++
 rtl/action_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// nav_pkg: encodings shared by the navigation-side control blocks.
//   task_state_e : task_fsm state as seen on state_enc
//   action_e     : motor command codes
//   grant_id_e   : owner of the command currently on the motor channel
//   arb_state_e  : action_arbiter sequencing state
//   requester_eligible() : whether a requester may hold the channel in a task state
package nav_pkg;

    typedef enum logic [2:0] {
        TS_IDLE     = 3'd0,
        TS_NAVIGATE = 3'd1,
        TS_INSPECT  = 3'd2,
        TS_TRANSMIT = 3'd3,
        TS_COMPLETE = 3'd4
    } task_state_e;

    typedef enum logic [1:0] {
        ACT_STOP  = 2'd0,
        ACT_FWD   = 2'd1,
        ACT_LEFT  = 2'd2,
        ACT_RIGHT = 2'd3
    } action_e;

    typedef enum logic [1:0] {
        GID_NONE   = 2'd0,
        GID_SAFETY = 2'd1,
        GID_NAV    = 2'd2,
        GID_INSP   = 2'd3
    } grant_id_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_HOLD  = 2'd2,
        ARB_FAULT = 2'd3
    } arb_state_e;

    // Safety (and an ownerless command) is never tied to a task state.
    function automatic logic requester_eligible(input logic [1:0] id, input logic [2:0] st);
        logic ok;
        case (id)
            GID_NAV:  ok = (st == TS_NAVIGATE);
            GID_INSP: ok = (st == TS_INSPECT);
            default:  ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/action_prio_sel.sv
// action_prio_sel: eligibility mask and fixed-priority select for the three
// action requesters (safety > nav > insp).
//   en             : selection allowed (arbiter idle, out of reset)
//   state_enc      : task_fsm state, gates nav and insp
//   *_valid/*_action : requester inputs
//   ready[2:0]     : one-hot grant {insp, nav, safety}
//   sel_action     : action of the selected requester (STOP when none)
//   sel_id         : grant id of the selected requester (NONE when none)
module action_prio_sel
    import nav_pkg::*;
(
    input  logic       en,
    input  logic [2:0] state_enc,
    input  logic       safety_valid,
    input  logic [1:0] safety_action,
    input  logic       nav_valid,
    input  logic [1:0] nav_action,
    input  logic       insp_valid,
    input  logic [1:0] insp_action,
    output logic [2:0] ready,
    output logic [1:0] sel_action,
    output logic [1:0] sel_id
);

    logic nav_req;
    logic insp_req;

    assign nav_req  = nav_valid  && requester_eligible(GID_NAV,  state_enc);
    assign insp_req = insp_valid && requester_eligible(GID_INSP, state_enc);

    always_comb begin
        ready      = 3'b000;
        sel_action = ACT_STOP;
        sel_id     = GID_NONE;
        if (en) begin
            if (safety_valid) begin
                ready      = 3'b001;
                sel_action = safety_action;
                sel_id     = GID_SAFETY;
            end else if (nav_req) begin
                ready      = 3'b010;
                sel_action = nav_action;
                sel_id     = GID_NAV;
            end else if (insp_req) begin
                ready      = 3'b100;
                sel_action = insp_action;
                sel_id     = GID_INSP;
            end
        end
    end

endmodule

// File: rtl/action_arbiter.sv
// action_arbiter: shares the motor-command channel between the safety monitor,
// navigation and inspection, with a minimum hold per command, safety
// preemption, task-exit abort and a driver-timeout fault.
//   clk, rst (async, active-low)
//   state_enc                      : task_fsm state
//   safety/nav/insp _valid,_action : requests; _ready accepts them (combinational)
//   motor_valid, motor_action      : command to the driver; motor_ready accepts it
//   grant_id                       : owner of the current command
//   busy                           : arbiter not idle
//   fault, fault_clr               : latched driver timeout and its clear pulse
//
// state | meaning
// IDLE  | grant highest-priority eligible requester
// ISSUE | command offered to driver, timeout running, no preemption
// HOLD  | command accepted, minimum hold running; safety preempt / task-exit abort
// FAULT | driver never accepted; channel forced to STOP until fault_clr
module action_arbiter
    import nav_pkg::*;
#(
    parameter int HOLD_CYCLES    = 50,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state_enc,
    input  logic       safety_valid,
    input  logic [1:0] safety_action,
    output logic       safety_ready,
    input  logic       nav_valid,
    input  logic [1:0] nav_action,
    output logic       nav_ready,
    input  logic       insp_valid,
    input  logic [1:0] insp_action,
    output logic       insp_ready,
    output logic       motor_valid,
    output logic [1:0] motor_action,
    input  logic       motor_ready,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       fault,
    input  logic       fault_clr
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e    state;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    idle_ready;
    logic [1:0]    sel_action;
    logic [1:0]    sel_id;
    logic          preempt;
    logic          abort;

    // Readies are held low while reset is asserted, even with valids high.
    action_prio_sel u_prio_sel (
        .en            (state == ARB_IDLE && rst),
        .state_enc     (state_enc),
        .safety_valid  (safety_valid),
        .safety_action (safety_action),
        .nav_valid     (nav_valid),
        .nav_action    (nav_action),
        .insp_valid    (insp_valid),
        .insp_action   (insp_action),
        .ready         (idle_ready),
        .sel_action    (sel_action),
        .sel_id        (sel_id)
    );

    // motor_action still carries the latched command throughout HOLD.
    assign preempt = (state == ARB_HOLD) && safety_valid && (safety_action != motor_action);
    assign abort   = (state == ARB_HOLD) && !requester_eligible(grant_id, state_enc);

    assign safety_ready = idle_ready[0] | preempt;
    assign nav_ready    = idle_ready[1];
    assign insp_ready   = idle_ready[2];
    assign busy         = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_IDLE;
            motor_valid  <= 1'b0;
            motor_action <= ACT_STOP;
            grant_id     <= GID_NONE;
            fault        <= 1'b0;
            hold_cnt     <= '0;
            tmo_cnt      <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|idle_ready) begin
                        state        <= ARB_ISSUE;
                        motor_valid  <= 1'b1;
                        motor_action <= sel_action;
                        grant_id     <= sel_id;
                        tmo_cnt      <= TW'(TIMEOUT_CYCLES);
                    end
                end
                ARB_ISSUE: begin
                    if (motor_ready) begin
                        state       <= ARB_HOLD;
                        motor_valid <= 1'b0;
                        hold_cnt    <= HW'(HOLD_CYCLES);
                        tmo_cnt     <= '0;
                    end else if (tmo_cnt <= TW'(1)) begin
                        state        <= ARB_FAULT;
                        motor_valid  <= 1'b0;
                        motor_action <= ACT_STOP;
                        grant_id     <= GID_NONE;
                        fault        <= 1'b1;
                        tmo_cnt      <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                ARB_HOLD: begin
                    // Safety outranks abort, and both outrank hold expiry.
                    if (preempt) begin
                        state        <= ARB_ISSUE;
                        motor_valid  <= 1'b1;
                        motor_action <= safety_action;
                        grant_id     <= GID_SAFETY;
                        tmo_cnt      <= TW'(TIMEOUT_CYCLES);
                        hold_cnt     <= '0;
                    end else if (abort) begin
                        state        <= ARB_ISSUE;
                        motor_valid  <= 1'b1;
                        motor_action <= ACT_STOP;
                        grant_id     <= GID_NONE;
                        tmo_cnt      <= TW'(TIMEOUT_CYCLES);
                        hold_cnt     <= '0;
                    end else if (hold_cnt <= HW'(1)) begin
                        state    <= ARB_IDLE;
                        grant_id <= GID_NONE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                ARB_FAULT: begin
                    if (fault_clr) begin
                        state <= ARB_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
